xy_route_unit: RTL and testbench

- Registered, wormhole-aware route-computation stage for one router input port. Sits between the input buffer and the crossbar/arbiter.
- Decodes the destination from the head flit with dimension-ordered routing; XY or YX is selectable by parameter.
- Locks the route for the body and tail flits and forwards flits through a one-deep valid/ready pipeline register.

---
 rtl/xy_route_unit.sv | 132 +++++++++++++
 tb/tb_xy_route_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_route_unit.sv
// rtl/xy_route_unit.sv - dimension-ordered route stage with wormhole route lock and one-deep output register
// Optional drop-and-count of protocol-violating flits: define ROUTE_CHK_EN.
module xy_route_unit #(
   parameter int COL_CORD     = 0,
   parameter int ROW_CORD     = 0,
   parameter int COL_ADDR_W   = 4,
   parameter int ROW_ADDR_W   = 4,
   parameter int OUT_N_W      = 3,
   parameter int FLIT_DATA_W  = 8,
   parameter int FLIT_ID_W    = 2,
   parameter int ROUTING_MODE = 0
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [FLIT_ID_W+FLIT_DATA_W-1:0] flit_i,
   input  logic                             valid_i,
   output logic                             ready_o,
   output logic [FLIT_ID_W+FLIT_DATA_W-1:0] flit_o,
   output logic [OUT_N_W-1:0]               out_chan_sel_o,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic                             locked_o
`ifdef ROUTE_CHK_EN
   ,
   output logic                             err_o,
   output logic [7:0]                       err_cnt_o
`endif
);

   localparam int FW = FLIT_ID_W + FLIT_DATA_W;

   localparam logic [OUT_N_W-1:0] P_RES   = OUT_N_W'(0);
   localparam logic [OUT_N_W-1:0] P_LEFT  = OUT_N_W'(1);
   localparam logic [OUT_N_W-1:0] P_UP    = OUT_N_W'(2);
   localparam logic [OUT_N_W-1:0] P_RIGHT = OUT_N_W'(3);
   localparam logic [OUT_N_W-1:0] P_DOWN  = OUT_N_W'(4);

   localparam logic [COL_ADDR_W-1:0] MY_COL = COL_ADDR_W'(COL_CORD);
   localparam logic [ROW_ADDR_W-1:0] MY_ROW = ROW_ADDR_W'(ROW_CORD);

   localparam logic [1:0] ID_BODY = 2'b00;
   localparam logic [1:0] ID_TAIL = 2'b01;
   localparam logic [1:0] ID_HEAD = 2'b10;
   localparam logic [1:0] ID_HT   = 2'b11;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state_q, state_d;
   logic [OUT_N_W-1:0]   hold_q, hold_d;
   logic [OUT_N_W-1:0]   calc_route, route;
   logic [COL_ADDR_W-1:0] col;
   logic [ROW_ADDR_W-1:0] row;
   logic [1:0]           id;
   logic                 xfer_in, xfer_out, load, drop;

   assign id       = flit_i[FW-1 -: 2];
   assign col      = flit_i[COL_ADDR_W-1:0];
   assign row      = flit_i[COL_ADDR_W +: ROW_ADDR_W];
   assign ready_o  = !valid_o || ready_i;
   assign xfer_in  = valid_i && ready_o;
   assign xfer_out = valid_o && ready_i;
   assign locked_o = (state_q == LOCKED);

   always_comb begin
      calc_route = P_RES;
      if (ROUTING_MODE == 0) begin
         if (col != MY_COL)      calc_route = (col > MY_COL) ? P_RIGHT : P_LEFT;
         else if (row != MY_ROW) calc_route = (row < MY_ROW) ? P_UP : P_DOWN;
      end else begin
         if (row != MY_ROW)      calc_route = (row < MY_ROW) ? P_UP : P_DOWN;
         else if (col != MY_COL) calc_route = (col > MY_COL) ? P_RIGHT : P_LEFT;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      route   = hold_q;
      load    = 1'b0;
      drop    = 1'b0;
      if (xfer_in) begin
         if (id[1]) route = calc_route;
`ifdef ROUTE_CHK_EN
         // head-type flits are illegal mid-packet, body/tail illegal between packets
         if ((state_q == LOCKED) == id[1]) drop = 1'b1;
`endif
         if (!drop) begin
            load = 1'b1;
            case (id)
               ID_HEAD: begin hold_d = calc_route; state_d = LOCKED; end
               ID_HT:   begin hold_d = calc_route; state_d = IDLE;   end
               ID_TAIL: state_d = IDLE;
               ID_BODY: ;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         hold_q         <= P_RES;
         valid_o        <= 1'b0;
         flit_o         <= '0;
         out_chan_sel_o <= P_RES;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         if (load) begin
            valid_o        <= 1'b1;
            flit_o         <= flit_i;
            out_chan_sel_o <= route;
         end else if (xfer_out) begin
            valid_o <= 1'b0;
         end
      end
   end

`ifdef ROUTE_CHK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_o     <= 1'b0;
         err_cnt_o <= 8'd0;
      end else begin
         err_o <= drop;
         if (drop && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_xy_route_unit.sv
// tb/tb_xy_route_unit.sv - self-checking bench for xy_route_unit (XY and YX instances, ROUTE_CHK_EN aware)
module tb_xy_route_unit;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [9:0] flit_i = '0;
   logic       valid_i = 1'b0;
   logic       ready_i = 1'b0;

   logic       ready_xy, valid_xy, locked_xy, ready_yx, valid_yx, locked_yx;
   logic [9:0] flit_xy, flit_yx;
   logic [2:0] sel_xy, sel_yx;
`ifdef ROUTE_CHK_EN
   logic       err_xy, err_yx;
   logic [7:0] cnt_xy, cnt_yx;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   xy_route_unit #(.COL_CORD(2), .ROW_CORD(2), .ROUTING_MODE(0)) dut_xy (
      .clk_i(clk_i), .rst_ni(rst_ni), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_xy),
      .flit_o(flit_xy), .out_chan_sel_o(sel_xy), .valid_o(valid_xy), .ready_i(ready_i),
      .locked_o(locked_xy)
`ifdef ROUTE_CHK_EN
      , .err_o(err_xy), .err_cnt_o(cnt_xy)
`endif
   );

   xy_route_unit #(.COL_CORD(2), .ROW_CORD(2), .ROUTING_MODE(1)) dut_yx (
      .clk_i(clk_i), .rst_ni(rst_ni), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_yx),
      .flit_o(flit_yx), .out_chan_sel_o(sel_yx), .valid_o(valid_yx), .ready_i(ready_i),
      .locked_o(locked_yx)
`ifdef ROUTE_CHK_EN
      , .err_o(err_yx), .err_cnt_o(cnt_yx)
`endif
   );

   // scoreboard: flits accepted but not yet delivered, with the route each instance must show
   typedef struct {
      logic [9:0] f;
      logic [2:0] sx;
      logic [2:0] sy;
   } exp_t;
   exp_t q[$];
   bit         m_locked;
   logic [2:0] m_hold_x, m_hold_y;
   bit         m_err;
   int         m_cnt;

   typedef struct {
      logic [3:0] col;
      logic [3:0] row;
      logic [2:0] exp_xy;
      logic [2:0] exp_yx;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // router sits at (2,2); route from signed offsets to the destination
   function automatic logic [2:0] ref_route(input logic [3:0] col, input logic [3:0] row, input bit yx);
      int dx, dy;
      dx = int'(col) - 2;
      dy = int'(row) - 2;
      if (!yx) begin
         if (dx > 0) return 3'd3;
         if (dx < 0) return 3'd1;
         if (dy < 0) return 3'd2;
         if (dy > 0) return 3'd4;
      end else begin
         if (dy < 0) return 3'd2;
         if (dy > 0) return 3'd4;
         if (dx > 0) return 3'd3;
         if (dx < 0) return 3'd1;
      end
      return 3'd0;
   endfunction

   task automatic model_clear();
      q.delete();
      m_locked = 0;
      m_hold_x = 3'd0;
      m_hold_y = 3'd0;
      m_err    = 0;
      m_cnt    = 0;
   endtask

   task automatic drive_cycle(input logic v, input logic r, input logic [9:0] f);
      bit exp_ready, tin, tout, bad;
      exp_t e;
      valid_i = v;
      ready_i = r;
      flit_i  = f;
      #1;
      exp_ready = (q.size() == 0) || r;
      check("valid_xy", valid_xy, q.size() != 0);
      check("valid_yx", valid_yx, q.size() != 0);
      check("ready_xy", ready_xy, exp_ready);
      check("ready_yx", ready_yx, exp_ready);
      check("locked_xy", locked_xy, m_locked);
      check("locked_yx", locked_yx, m_locked);
      if (q.size() != 0) begin
         check("flit_xy", flit_xy, q[0].f);
         check("sel_xy", sel_xy, q[0].sx);
         check("flit_yx", flit_yx, q[0].f);
         check("sel_yx", sel_yx, q[0].sy);
      end
`ifdef ROUTE_CHK_EN
      check("err_o", err_xy, m_err);
      check("err_cnt_o", cnt_xy, m_cnt);
      check("err_cnt_yx", cnt_yx, m_cnt);
`endif
      tout = (q.size() != 0) && r;
      tin  = v && exp_ready;
      if (tout) void'(q.pop_front());
      m_err = 0;
      if (tin) begin
         bad = 0;
`ifdef ROUTE_CHK_EN
         bad = m_locked ? f[9] : !f[9];
`endif
         if (bad) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
         end else if (f[9]) begin
            m_hold_x = ref_route(f[3:0], f[7:4], 0);
            m_hold_y = ref_route(f[3:0], f[7:4], 1);
            e.f = f; e.sx = m_hold_x; e.sy = m_hold_y;
            q.push_back(e);
            m_locked = (f[8] == 1'b0);
         end else begin
            e.f = f; e.sx = m_hold_x; e.sy = m_hold_y;
            q.push_back(e);
            if (f[8]) m_locked = 0;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      valid_i = 1'b0;
      rst_ni  = 1'b0;
      #1;
      model_clear();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      vecs[0] = '{4'd5,  4'd1,  3'd3, 3'd2};
      vecs[1] = '{4'd0,  4'd1,  3'd1, 3'd2};
      vecs[2] = '{4'd2,  4'd0,  3'd2, 3'd2};
      vecs[3] = '{4'd2,  4'd3,  3'd4, 3'd4};
      vecs[4] = '{4'd2,  4'd2,  3'd0, 3'd0};
      vecs[5] = '{4'd0,  4'd2,  3'd1, 3'd1};
      vecs[6] = '{4'd15, 4'd15, 3'd3, 3'd4};
      vecs[7] = '{4'd1,  4'd3,  3'd1, 3'd4};

      model_clear();
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #1;
      check("rst_valid", valid_xy, 1'b0);
      check("rst_flit", flit_xy, 10'h0);
      check("rst_sel", sel_xy, 3'd0);
      check("rst_locked", locked_xy, 1'b0);
      check("rst_ready", ready_xy, 1'b1);

      // single-flit packets, result visible one cycle after acceptance
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, 1'b1, {2'b11, vecs[i].row, vecs[i].col});
         check("tbl_valid", valid_xy, 1'b1);
         check("tbl_sel_xy", sel_xy, vecs[i].exp_xy);
         check("tbl_sel_yx", sel_yx, vecs[i].exp_yx);
         check("tbl_locked", locked_xy, 1'b0);
      end
      drive_cycle(1'b0, 1'b1, 10'h0);

      // wormhole packet: HEAD (4,2) then BODY, BODY, TAIL
      drive_cycle(1'b1, 1'b1, {2'b10, 4'd2, 4'd4});
      check("wh_head_sel", sel_xy, 3'd3);
      check("wh_head_lock", locked_xy, 1'b1);
      drive_cycle(1'b1, 1'b1, {2'b00, 8'hAB});
      check("wh_body1_sel", sel_xy, 3'd3);
      check("wh_body1_lock", locked_xy, 1'b1);
      drive_cycle(1'b1, 1'b1, {2'b00, 8'hCD});
      check("wh_body2_sel", sel_xy, 3'd3);
      drive_cycle(1'b1, 1'b1, {2'b01, 8'hEF});
      check("wh_tail_sel", sel_xy, 3'd3);
      check("wh_tail_lock", locked_xy, 1'b0);
      drive_cycle(1'b0, 1'b1, 10'h0);
      check("wh_drained", valid_xy, 1'b0);

      // backpressure: A held for 3 cycles while B waits, then both move in order
      drive_cycle(1'b1, 1'b1, {2'b11, 8'h15});
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b0, {2'b11, 8'h20});
         check("bp_ready", ready_xy, 1'b0);
         check("bp_flit_stable", flit_xy, {2'b11, 8'h15});
         check("bp_sel_stable", sel_xy, 3'd3);
      end
      drive_cycle(1'b1, 1'b1, {2'b11, 8'h20});
      check("bp_next_flit", flit_xy, {2'b11, 8'h20});
      check("bp_next_sel", sel_xy, 3'd1);
      drive_cycle(1'b0, 1'b1, 10'h0);
      check("bp_drained", valid_xy, 1'b0);

      // reset mid-packet
      drive_cycle(1'b1, 1'b1, {2'b10, 8'h25});
      drive_cycle(1'b1, 1'b1, {2'b00, 8'h11});
      valid_i = 1'b0;
      rst_ni  = 1'b0;
      #1;
      check("mid_rst_valid", valid_xy, 1'b0);
      check("mid_rst_locked", locked_xy, 1'b0);
      model_clear();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      drive_cycle(1'b1, 1'b1, {2'b00, 8'h55});
`ifndef ROUTE_CHK_EN
      check("post_rst_body_sel", sel_xy, 3'd0);
      check("post_rst_body_valid", valid_xy, 1'b1);
`endif
      drive_cycle(1'b0, 1'b1, 10'h0);

      // randomized traffic against the scoreboard
      for (int i = 0; i < 400; i++)
         drive_cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), 10'($urandom));
      drive_cycle(1'b0, 1'b1, 10'h0);

`ifdef ROUTE_CHK_EN
      do_reset();
      drive_cycle(1'b1, 1'b1, {2'b01, 8'h33});
      check("chk_not_fwd", valid_xy, 1'b0);
      check("chk_err_pulse", err_xy, 1'b1);
      check("chk_cnt1", cnt_xy, 8'd1);
      drive_cycle(1'b0, 1'b1, 10'h0);
      check("chk_err_clear", err_xy, 1'b0);
      for (int i = 0; i < 300; i++) drive_cycle(1'b1, 1'b1, {2'b01, 8'h33});
      check("chk_cnt_sat", cnt_xy, 8'd255);
      drive_cycle(1'b0, 1'b1, 10'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
